scroll_display_ctrl: RTL

Parametrised multi-digit scrolling 7-segment display controller. It holds a message of hex nibbles in an internal register buffer and shows a NUM_DIGITS-wide window onto it. The window advances one position every TICK_DIV clock cycles, in either direction, with wrap-around. It sits between board-level control logic (switches, FSM) and the 7-segment pins and generalises the fixed 4-digit scroller.

---
 rtl/scroll_pkg.sv | 18 +
 rtl/hex_to_seg7.sv | 11 +
 rtl/scroll_display_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling 7-segment display controller.
package scroll_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    // Active-high segment patterns {g,f,e,d,c,b,a}, entry 15 first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment decoder.
module hex_to_seg7
    import scroll_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/scroll_display_ctrl.sv
// Scrolling multi-digit 7-segment controller over a nibble message buffer.
// Define SCROLL_BLINK_EN to blink the window while paused.
module scroll_display_ctrl
    import scroll_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int MSG_DEPTH      = 16,
    parameter int TICK_DIV       = 50000000,
    parameter int SEG_ACTIVE_LOW = 1,
    localparam int AW            = $clog2(MSG_DEPTH),
    localparam int TW            = $clog2(TICK_DIV),
    localparam int SEG_W         = 7 * NUM_DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [3:0]       wr_data,
    input  logic [AW:0]      msg_len,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    output logic [SEG_W-1:0] seg_out,
    output logic [AW-1:0]    pos,
    output logic             busy
);

    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [AW:0]      LEN_MAX   = (AW + 1)'(MSG_DEPTH);
    localparam logic             INV       = (SEG_ACTIVE_LOW != 0);
    localparam logic [SEG_W-1:0] BLANK_OUT = {NUM_DIGITS{SEG_BLANK}} ^ {SEG_W{INV}};

    state_t            state, state_next;
    logic [TW-1:0]     tick_q, tick_d;
    logic [AW-1:0]     pos_q, pos_d;
    logic [AW:0]       len_q, len_d;
    logic [AW:0]       last;
    logic              pos_is_last;
    logic              hide;
    logic [3:0]        msg_buf [MSG_DEPTH];
    logic [SEG_W-1:0]  window;
    logic [SEG_W-1:0]  seg_q;

    assign last        = len_q - 1'b1;
    assign pos_is_last = ({1'b0, pos_q} == last);

    always_comb begin
        state_next = state;
        tick_d     = tick_q;
        pos_d      = pos_q;
        len_d      = len_q;
        // A start with an empty message is treated exactly like stop.
        if (stop || (start && msg_len == '0)) begin
            state_next = IDLE;
            tick_d     = '0;
            pos_d      = '0;
        end else if (start) begin
            len_d      = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
            tick_d     = '0;
            pos_d      = '0;
            state_next = (state != IDLE && pause) ? PAUSED : RUN;
        end else begin
            case (state)
                RUN: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (dir) pos_d = (pos_q == '0) ? last[AW-1:0] : pos_q - 1'b1;
                        else     pos_d = pos_is_last ? '0 : pos_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                    if (pause) state_next = PAUSED;
                end
                PAUSED:  if (!pause) state_next = RUN;
                IDLE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            tick_q <= '0;
            pos_q  <= '0;
            len_q  <= '0;
        end else begin
            state  <= state_next;
            tick_q <= tick_d;
            pos_q  <= pos_d;
            len_q  <= len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSG_DEPTH; i++) msg_buf[i] <= '0;
        end else if (wr_en) begin
            msg_buf[wr_addr] <= wr_data;
        end
    end

    // Digit indices walk forward from pos and wrap at len, so no divider is needed.
    logic [AW:0] idx     [NUM_DIGITS];
    logic [6:0]  dig_seg [NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        if (g == 0) begin : g_first
            assign idx[g] = {1'b0, pos_q};
        end else begin : g_next
            assign idx[g] = (idx[g-1] == last) ? '0 : idx[g-1] + 1'b1;
        end
        hex_to_seg7 u_dec (
            .nibble (msg_buf[idx[g][AW-1:0]]),
            .seg    (dig_seg[g])
        );
        assign window[7*(NUM_DIGITS-1-g) +: 7] = dig_seg[g];
    end

`ifdef SCROLL_BLINK_EN
    logic [TW-1:0] blink_cnt;
    logic          blink_off;

    always_ff @(posedge clk) begin
        if (rst || state != PAUSED) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == TICK_LAST) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign hide = (state == IDLE) || (state_next == IDLE) || (state == PAUSED && blink_off);
`else
    assign hide = (state == IDLE) || (state_next == IDLE);
`endif

    always_ff @(posedge clk) begin
        if (rst) seg_q <= BLANK_OUT;
        else     seg_q <= (hide ? {NUM_DIGITS{SEG_BLANK}} : window) ^ {SEG_W{INV}};
    end

    assign seg_out = seg_q;
    assign pos     = pos_q;
    assign busy    = (state != IDLE);

endmodule
